// File: rtl/vpu_pkg.sv
// Shared types for the accumulator drain path: drain FSM states and the tagged result word.
package vpu_pkg;
  localparam int VPU_ACC_WIDTH  = 32;
  localparam int VPU_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} drain_state_t;

  typedef struct packed {
    logic [VPU_ACC_WIDTH-1:0]  data;
    logic [VPU_ADDR_WIDTH-1:0] row;
    logic [VPU_ADDR_WIDTH-1:0] col;
    logic                      last;
  } acc_word_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: dout_o shows the head whenever count_o is non-zero.
// Push and pop in the same cycle are legal even when full; the caller guarantees no overflow.
module sync_fifo_fwft
  import vpu_pkg::*;
#(
  parameter type T     = acc_word_t,
  parameter int  DEPTH = 4
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  T                             din_i,
  input  logic                         pop_i,
  output T                             dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= ptr_inc(wptr_q);
      if (pop_i)  rptr_q <= ptr_inc(rptr_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign dout_o  = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
endmodule

// File: rtl/acc_drain_reader.sv
// Sweeps the accumulator bank once per start and streams each word out with row/col/last tags.
// Issue is credit-gated so every outstanding read already owns a FIFO slot when acc_in arrives.
module acc_drain_reader
  import vpu_pkg::*;
#(
  parameter int MATRIX_SIZE    = 8,
  parameter int ACC_WIDTH      = 32,
  parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE*MATRIX_SIZE),
  parameter int ADDR_WIDTH     = $clog2(MATRIX_SIZE),
  parameter int READ_LATENCY   = 1,
  parameter int FIFO_DEPTH     = 4
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      clear_acc,
  output logic                      busy,
  output logic                      done,
  output logic [ACC_ADDR_WIDTH-1:0] addr_acc,
  input  logic [ACC_WIDTH-1:0]      acc_in,
  output logic                      acc_rst,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic [ADDR_WIDTH-1:0]     out_row,
  output logic [ADDR_WIDTH-1:0]     out_col,
  output logic                      out_last
);
  localparam int NWORDS = MATRIX_SIZE * MATRIX_SIZE;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int CNTW   = ACC_ADDR_WIDTH + 1;
  localparam bit POW2   = (MATRIX_SIZE & (MATRIX_SIZE - 1)) == 0;

  typedef struct packed {
    logic [ACC_WIDTH-1:0]  data;
    logic [ADDR_WIDTH-1:0] row;
    logic [ADDR_WIDTH-1:0] col;
    logic                  last;
  } word_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] row;
    logic [ADDR_WIDTH-1:0] col;
    logic                  last;
  } tag_t;

  drain_state_t              state_q, state_d;
  logic [CNTW-1:0]           issue_cnt_q, issue_cnt_d;
  logic [ACC_ADDR_WIDTH-1:0] last_addr_q;
  logic                      clr_q, clr_d;
  logic                      start_ok, issue_fire, issue_last, pop;
  logic [ADDR_WIDTH-1:0]     tag_row, tag_col;
  tag_t                      issue_tag, cap_tag;
  logic                      cap_vld;
  logic [CW-1:0]             inflight, fifo_cnt;
  logic                      fifo_full, fifo_empty;
  word_t                     fifo_din, fifo_dout;

  assign start_ok   = (state_q == IDLE) && start;
  assign pop        = out_valid && out_ready;
  assign issue_last = (issue_cnt_q == CNTW'(NWORDS - 1));
  // Counting a same-cycle pop as a free slot is what sustains 1 word/clk at the minimum depth.
  assign issue_fire = (state_q == ISSUE) &&
                      ((int'(inflight) + int'(fifo_cnt) - int'(pop)) < FIFO_DEPTH);
  assign addr_acc   = issue_fire ? issue_cnt_q[ACC_ADDR_WIDTH-1:0] : last_addr_q;
  assign issue_tag  = '{row: tag_row, col: tag_col, last: issue_last};

  if (POW2) begin : g_shift_tag
    assign tag_row = ADDR_WIDTH'(issue_cnt_q >> ADDR_WIDTH);
    assign tag_col = issue_cnt_q[ADDR_WIDTH-1:0];
  end else begin : g_cnt_tag
    logic [ADDR_WIDTH-1:0] row_q, col_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        row_q <= '0;
        col_q <= '0;
      end else if (start_ok) begin
        row_q <= '0;
        col_q <= '0;
      end else if (issue_fire) begin
        if (col_q == ADDR_WIDTH'(MATRIX_SIZE - 1)) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
    assign tag_row = row_q;
    assign tag_col = col_q;
  end

  if (READ_LATENCY == 0) begin : g_rl0
    assign cap_vld  = issue_fire;
    assign cap_tag  = issue_tag;
    assign inflight = '0;
  end else begin : g_tag_pipe
    logic [READ_LATENCY-1:0] vld_q;
    tag_t [READ_LATENCY-1:0] tag_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q <= '0;
        tag_q <= '0;
      end else begin
        vld_q[0] <= issue_fire;
        tag_q[0] <= issue_tag;
        for (int i = 1; i < READ_LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          tag_q[i] <= tag_q[i-1];
        end
      end
    end
    assign cap_vld  = vld_q[READ_LATENCY-1];
    assign cap_tag  = tag_q[READ_LATENCY-1];
    assign inflight = CW'($countones(vld_q));
  end

  assign fifo_din = '{data: acc_in, row: cap_tag.row, col: cap_tag.col, last: cap_tag.last};

  sync_fifo_fwft #(.T(word_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cap_vld),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assert property (@(posedge clk) disable iff (!rst) !(fifo_full && cap_vld && !pop));

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_dout.data : '0;
  assign out_row   = out_valid ? fifo_dout.row  : '0;
  assign out_col   = out_valid ? fifo_dout.col  : '0;
  assign out_last  = out_valid && fifo_dout.last;

  // Popping the last-tagged word means the pipe and FIFO are both drained from the next cycle.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    clr_d       = clr_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d     = ISSUE;
          issue_cnt_d = '0;
          clr_d       = clear_acc;
        end
      end
      ISSUE: begin
        if (issue_fire) issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_fire && issue_last) state_d = FLUSH;
      end
      FLUSH: if (pop && fifo_dout.last) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        clr_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      last_addr_q <= '0;
      clr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      clr_q       <= clr_d;
      if (issue_fire) last_addr_q <= issue_cnt_q[ACC_ADDR_WIDTH-1:0];
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign acc_rst = done && clr_q;
endmodule

// File: tb/tb_acc_drain_reader.sv
// Scoreboard bench for acc_drain_reader: main instance (latency 1) plus a latency 0..3 sweep.
module tb_acc_drain_reader;
  logic        clk = 1'b0;
  logic        rst, start, clear_acc, out_ready;
  logic        busy, done, acc_rst, out_valid, out_last;
  logic [5:0]  addr_acc;
  logic [31:0] acc_in, out_data;
  logic [2:0]  out_row, out_col;

  logic [3:0]  sw_start, sw_valid, sw_done, sw_busy, sw_rst, sw_last;
  logic [31:0] sw_data [4];
  logic [2:0]  sw_row [4];
  logic [2:0]  sw_col [4];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, words = 0, dones = 0, rsts = 0, last_xfer = -100;
  bit stall_q = 0, done_q = 0;
  logic [63:0] exp_q[$];
  logic [63:0] sw_q[$];

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) acc_in <= 32'(addr_acc) * 32'd3;

  acc_drain_reader #(.READ_LATENCY(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .clear_acc(clear_acc), .busy(busy), .done(done),
    .addr_acc(addr_acc), .acc_in(acc_in), .acc_rst(acc_rst), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    logic [5:0]  addr;
    logic [31:0] acc;
    if (g == 0) begin : g_comb
      assign acc = 32'(addr) * 32'd7 + 32'(g * 1000);
    end else begin : g_reg
      logic [31:0] dly [g];
      always @(posedge clk) begin
        dly[0] <= 32'(addr) * 32'd7 + 32'(g * 1000);
        for (int i = 1; i < g; i++) dly[i] <= dly[i-1];
      end
      assign acc = dly[g-1];
    end
    acc_drain_reader #(.READ_LATENCY(g), .FIFO_DEPTH(g + 1)) u_sw (
      .clk(clk), .rst(rst), .start(sw_start[g]), .clear_acc(1'b0), .busy(sw_busy[g]),
      .done(sw_done[g]), .addr_acc(addr), .acc_in(acc), .acc_rst(sw_rst[g]),
      .out_valid(sw_valid[g]), .out_ready(1'b1), .out_data(sw_data[g]), .out_row(sw_row[g]),
      .out_col(sw_col[g]), .out_last(sw_last[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int i, input logic [31:0] d);
    logic [2:0] r, c;
    r = 3'(i / 8);
    c = 3'(i % 8);
    return 64'({d, r, c, (i == 63)});
  endfunction

  // Main-instance monitor: sampled on the falling edge, compares head against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      stall_q = 0;
      done_q  = 0;
    end else begin
      if (stall_q) chk("valid_held_while_stalled", 64'(out_valid), 64'd1);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("scoreboard_underflow", 64'(exp_q.size()), 64'd1);
        else begin
          chk("word", 64'({out_data, out_row, out_col, out_last}), exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            words++;
            last_xfer = cyc;
          end
        end
      end
      if (done) begin
        dones++;
        chk("done_after_last", 64'(cyc), 64'(last_xfer + 1));
      end
      if (acc_rst) begin
        rsts++;
        chk("acc_rst_with_done", 64'(done), 64'd1);
      end
      if (done_q) chk("busy_drop_after_done", 64'(busy), 64'd0);
      stall_q = out_valid && !out_ready;
      done_q  = done;
    end
  end

  task automatic run_drain(input bit clr, input bit rnd, input int inj_at, input int abort_at,
                           input bit lat);
    int x, guard;
    bit fv, injd;
    words = 0; dones = 0; rsts = 0; injd = 0;
    for (int i = 0; i < 64; i++) exp_q.push_back(mk(i, 32'(i) * 32'd3));
    @(posedge clk); #1;
    x = cyc; start = 1; clear_acc = clr; out_ready = 1;
    @(posedge clk); #1;
    start = 0; clear_acc = 0;
    chk("busy_after_start", 64'(busy), 64'd1);
    if (lat) begin
      fv = 0;
      for (int c = 0; c < 8 && !fv; c++) begin
        @(negedge clk);
        if (out_valid) begin
          fv = 1;
          chk("first_valid_latency", 64'(cyc - x), 64'd3);
        end
      end
      chk("first_valid_seen", 64'(fv), 64'd1);
    end
    guard = 0;
    while (dones == 0 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
      start = 0; clear_acc = 0;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (inj_at >= 0 && !injd && words >= inj_at) begin
        start = 1; clear_acc = 1; injd = 1;
      end
      if (abort_at >= 0 && words >= abort_at) begin
        #2 rst = 0;
        #1 chk("abort_outputs_zero",
               64'({busy, done, addr_acc, acc_rst, out_valid, out_data, out_row, out_col, out_last}),
               64'd0);
        exp_q.delete();
        start = 0; clear_acc = 0;
        @(posedge clk); #3 rst = 1;
        return;
      end
    end
    chk("drain_finished", 64'(guard < 2000), 64'd1);
    start = 0; clear_acc = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("word_count", 64'(words), 64'd64);
    chk("done_count", 64'(dones), 64'd1);
    chk("acc_rst_count", 64'(rsts), 64'(clr));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_sweep(input int k);
    int x, first, lastc, n;
    bit seen_done, any_rst;
    sw_q.delete();
    for (int i = 0; i < 64; i++) sw_q.push_back(mk(i, 32'(i) * 32'd7 + 32'(k * 1000)));
    @(posedge clk); #1;
    x = cyc; sw_start[k] = 1'b1;
    @(posedge clk); #1;
    sw_start[k] = 1'b0;
    chk($sformatf("sw%0d_busy", k), 64'(sw_busy[k]), 64'd1);
    first = -1; lastc = -1; n = 0; seen_done = 0; any_rst = 0;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      @(negedge clk);
      any_rst |= sw_rst[k];
      if (sw_valid[k]) begin
        if (first < 0) first = cyc;
        if (sw_q.size() == 0) chk($sformatf("sw%0d_underflow", k), 64'(sw_q.size()), 64'd1);
        else chk($sformatf("sw%0d_word", k),
                 64'({sw_data[k], sw_row[k], sw_col[k], sw_last[k]}), sw_q.pop_front());
        lastc = cyc;
        n++;
      end
      if (sw_done[k]) seen_done = 1;
    end
    chk($sformatf("sw%0d_first_latency", k), 64'(first - x), 64'(k + 2));
    chk($sformatf("sw%0d_words", k), 64'(n), 64'd64);
    chk($sformatf("sw%0d_rate", k), 64'(lastc - first), 64'd63);
    chk($sformatf("sw%0d_done", k), 64'(seen_done), 64'd1);
    chk($sformatf("sw%0d_no_acc_rst", k), 64'(any_rst), 64'd0);
    @(negedge clk);
    chk($sformatf("sw%0d_busy_drop", k), 64'(sw_busy[k]), 64'd0);
  endtask

  initial begin
    rst = 1; start = 0; clear_acc = 0; out_ready = 0; sw_start = '0;
    #2 rst = 0;
    #10;
    chk("reset_outputs",
        64'({busy, done, addr_acc, acc_rst, out_valid, out_data, out_row, out_col, out_last}), 64'd0);
    chk("reset_sweep_valid", 64'(sw_valid), 64'd0);
    chk("reset_sweep_busy", 64'(sw_busy), 64'd0);
    #10 rst = 1;

    run_drain(1'b0, 1'b0, -1, -1, 1'b1);   // straight drain, latency check
    run_drain(1'b0, 1'b1, -1, -1, 1'b0);   // random backpressure
    run_drain(1'b1, 1'b1, -1, -1, 1'b0);   // clear_acc latched
    run_drain(1'b0, 1'b0, -1, -1, 1'b0);   // clear_acc not latched
    run_drain(1'b0, 1'b0, 10, -1, 1'b0);   // start while busy
    run_drain(1'b1, 1'b1, -1, 20, 1'b0);   // reset mid-drain
    run_drain(1'b0, 1'b0, -1, -1, 1'b0);   // restart after reset
    for (int k = 0; k < 4; k++) run_sweep(k);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL global_timeout: got running, expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "bench timeout");
  end
endmodule
